// File: rtl/rom_download_pkg.sv
// ============================================================================
// rom_download_pkg : shared types and default region map for the ROM loader
// Revision: 1.0
// ============================================================================
`default_nettype none

package rom_download_pkg;

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    RUN  = 2'd3
  } state_t;

  typedef logic [1:0] region_idx_t;

  localparam logic [15:0] DEF_R0_END      = 16'h6000;
  localparam logic [15:0] DEF_R1_END      = 16'h7000;
  localparam logic [15:0] DEF_R2_END      = 16'h9000;
  localparam logic [15:0] DEF_R3_END      = 16'hD000;
  localparam int          DEF_HOLD_CYCLES = 256;

  function automatic logic [3:0] region_onehot(input region_idx_t idx);
    region_onehot = 4'b0001 << idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rom_region_decode.sv
// ============================================================================
// rom_region_decode : ioctl byte address -> in-range flag, one-hot region, offset
// Revision: 1.0
// ============================================================================
`default_nettype none

module rom_region_decode
  import rom_download_pkg::*;
#(
  parameter logic [15:0] R0_END = DEF_R0_END,
  parameter logic [15:0] R1_END = DEF_R1_END,
  parameter logic [15:0] R2_END = DEF_R2_END,
  parameter logic [15:0] R3_END = DEF_R3_END
) (
  input  logic [24:0] addr_i,
  output logic        in_range_o,
  output logic [3:0]  region_oh_o,
  output logic [15:0] offset_o
);

  logic [15:0] w_lo;
  region_idx_t w_idx;
  logic [15:0] w_base;

  assign w_lo = addr_i[15:0];

  // Regions are contiguous, each based at the previous region's end.
  always_comb begin
    w_idx  = 2'd0;
    w_base = 16'h0000;
    if (w_lo < R0_END) begin
      w_idx  = 2'd0;
      w_base = 16'h0000;
    end else if (w_lo < R1_END) begin
      w_idx  = 2'd1;
      w_base = R0_END;
    end else if (w_lo < R2_END) begin
      w_idx  = 2'd2;
      w_base = R1_END;
    end else begin
      w_idx  = 2'd3;
      w_base = R2_END;
    end
  end

  assign in_range_o  = (addr_i[24:16] == 9'd0) && (w_lo < R3_END);
  assign region_oh_o = region_onehot(w_idx);
  assign offset_o    = w_lo - w_base;

endmodule

`default_nettype wire

// File: rtl/rom_download_ctl.sv
// ============================================================================
// rom_download_ctl : routes the ioctl download into four ROM regions and gates core reset
// Revision: 1.0
// ============================================================================
`default_nettype none

module rom_download_ctl
  import rom_download_pkg::*;
#(
  parameter logic [15:0] R0_END      = DEF_R0_END,
  parameter logic [15:0] R1_END      = DEF_R1_END,
  parameter logic [15:0] R2_END      = DEF_R2_END,
  parameter logic [15:0] R3_END      = DEF_R3_END,
  parameter int          HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [3:0]  rom_we,
  output logic [15:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        core_reset,
  output logic        load_ok,
  output logic        load_err,
  output logic [16:0] byte_count
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_t            state_q;
  logic [3:0]        rom_we_q;
  logic [15:0]       rom_addr_q;
  logic [7:0]        rom_data_q;
  logic              core_reset_q;
  logic              load_ok_q;
  logic              load_err_q;
  logic [16:0]       byte_count_q;
  logic [16:0]       byte_count_d;
  logic [HOLD_W-1:0] hold_q;

  logic              w_in_range;
  logic [3:0]        w_region_oh;
  logic [15:0]       w_offset;

  rom_region_decode #(
    .R0_END (R0_END),
    .R1_END (R1_END),
    .R2_END (R2_END),
    .R3_END (R3_END)
  ) u_decode (
    .addr_i      (ioctl_addr),
    .in_range_o  (w_in_range),
    .region_oh_o (w_region_oh),
    .offset_o    (w_offset)
  );

  assign byte_count_d = (byte_count_q == 17'h1FFFF) ? byte_count_q : byte_count_q + 17'd1;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q      <= WAIT;
      rom_we_q     <= 4'b0000;
      rom_addr_q   <= 16'h0000;
      rom_data_q   <= 8'h00;
      core_reset_q <= 1'b1;
      load_ok_q    <= 1'b0;
      load_err_q   <= 1'b0;
      byte_count_q <= 17'd0;
      hold_q       <= '0;
    end else begin
      rom_we_q <= 4'b0000;
      // A new download pre-empts every other state, discarding any pending hold.
      if ((state_q != LOAD) && ioctl_download) begin
        state_q      <= LOAD;
        core_reset_q <= 1'b1;
        load_ok_q    <= 1'b0;
        load_err_q   <= 1'b0;
        byte_count_q <= 17'd0;
      end else begin
        case (state_q)
          WAIT: core_reset_q <= 1'b1;
          LOAD: begin
            if (ioctl_download) begin
              if (ioctl_wr) begin
                if (w_in_range) begin
                  rom_we_q     <= w_region_oh;
                  rom_addr_q   <= w_offset;
                  rom_data_q   <= ioctl_dout;
                  byte_count_q <= byte_count_d;
                end else begin
                  load_err_q <= 1'b1;
                end
              end
            end else if ((byte_count_q >= {1'b0, R3_END}) && !load_err_q) begin
              state_q <= HOLD;
              hold_q  <= HOLD_W'(HOLD_CYCLES - 1);
            end else begin
              state_q    <= WAIT;
              load_err_q <= 1'b1;
            end
          end
          HOLD: begin
            if (hold_q == '0) begin
              state_q      <= RUN;
              core_reset_q <= 1'b0;
              load_ok_q    <= 1'b1;
            end else begin
              hold_q <= hold_q - HOLD_W'(1);
            end
          end
          RUN:     core_reset_q <= 1'b0;
          default: state_q <= WAIT;
        endcase
      end
    end
  end

  assign rom_we     = rom_we_q;
  assign rom_addr   = rom_addr_q;
  assign rom_data   = rom_data_q;
  assign core_reset = core_reset_q;
  assign load_ok    = load_ok_q;
  assign load_err   = load_err_q;
  assign byte_count = byte_count_q;

endmodule

`default_nettype wire

// File: tb/tb_rom_download_ctl.sv
// ============================================================================
// tb_rom_download_ctl : randomized scoreboard bench for rom_download_ctl
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rom_download_ctl;

  localparam logic [15:0] R0   = 16'h0180;
  localparam logic [15:0] R1   = 16'h0200;
  localparam logic [15:0] R2   = 16'h0280;
  localparam logic [15:0] R3   = 16'h0400;
  localparam int          HOLD = 20;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic [3:0]  rom_we;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic        core_reset;
  logic        load_ok;
  logic        load_err;
  logic [16:0] byte_count;

  rom_download_ctl #(
    .R0_END      (R0),
    .R1_END      (R1),
    .R2_END      (R2),
    .R3_END      (R3),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .rom_we         (rom_we),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .core_reset     (core_reset),
    .load_ok        (load_ok),
    .load_err       (load_err),
    .byte_count     (byte_count)
  );

  always #5 clk_sys = ~clk_sys;

  int          n_vec = 0;
  int          n_err = 0;
  logic [27:0] sb_q[$];
  logic [27:0] mon_e;
  int          exp_count = 0;
  logic        exp_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected strobe word {we, offset, data} from the region map.
  function automatic logic [27:0] exp_strobe(input logic [15:0] a, input logic [7:0] d);
    logic [3:0]  we;
    logic [15:0] off;
    if (a < R0) begin
      we = 4'b0001; off = a;
    end else if (a < R1) begin
      we = 4'b0010; off = a - R0;
    end else if (a < R2) begin
      we = 4'b0100; off = a - R1;
    end else begin
      we = 4'b1000; off = a - R2;
    end
    return {we, off, d};
  endfunction

  always @(negedge clk_sys) begin
    if (!reset && rom_we != 4'b0000) begin
      if (sb_q.size() == 0) begin
        check("unexpected_strobe", {4'h0, rom_we, rom_addr, rom_data}, 32'h0);
      end else begin
        mon_e = sb_q.pop_front();
        check("strobe", {4'h0, rom_we, rom_addr, rom_data}, {4'h0, mon_e});
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic put(input logic [24:0] a, input logic [7:0] d);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    if (a[24:16] == 9'd0 && a[15:0] < R3) begin
      sb_q.push_back(exp_strobe(a[15:0], d));
      exp_count++;
    end else begin
      exp_err = 1'b1;
    end
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
  endtask

  task automatic idle(input int n);
    ioctl_wr = 1'b0;
    repeat (n) begin
      @(posedge clk_sys); #1;
    end
  endtask

  task automatic rise();
    ioctl_download = 1'b1;
    @(posedge clk_sys); #1;
    exp_count = 0;
    exp_err   = 1'b0;
  endtask

  task automatic fall(input bit with_wr);
    ioctl_download = 1'b0;
    ioctl_wr       = with_wr;
    ioctl_addr     = '0;
    ioctl_dout     = 8'($urandom);
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
    if (!(exp_count >= int'(R3) && !exp_err)) exp_err = 1'b1;
  endtask

  task automatic load_image(input bit shuffle, input int first, input int last);
    logic [15:0] order[$];
    logic [15:0] t;
    int j;
    for (int i = first; i < last; i++) order.push_back(16'(i));
    if (shuffle) begin
      for (int i = order.size() - 1; i > 0; i--) begin
        j = $urandom_range(i, 0);
        t = order[i]; order[i] = order[j]; order[j] = t;
      end
    end
    foreach (order[k]) begin
      if ($urandom_range(3, 0) == 0) idle(1);
      put({9'd0, order[k]}, 8'($urandom));
    end
  endtask

  task automatic measure_release(input string name, input int exp_n);
    int n;
    n = 0;
    while (core_reset === 1'b1 && n < HOLD + 50) begin
      @(posedge clk_sys); #1;
      n++;
    end
    check(name, 32'(n), 32'(exp_n));
  endtask

  task automatic check_status(input string tag);
    check({tag, "_count"}, 32'(byte_count), 32'(exp_count));
    check({tag, "_err"}, 32'(load_err), 32'(exp_err));
    check({tag, "_sb_empty"}, 32'(sb_q.size()), 32'h0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_core_reset"}, 32'(core_reset), 32'h1);
    check({tag, "_rom_we"}, 32'(rom_we), 32'h0);
    check({tag, "_rom_addr"}, 32'(rom_addr), 32'h0);
    check({tag, "_rom_data"}, 32'(rom_data), 32'h0);
    check({tag, "_load_ok"}, 32'(load_ok), 32'h0);
    check({tag, "_load_err"}, 32'(load_err), 32'h0);
    check({tag, "_byte_count"}, 32'(byte_count), 32'h0);
  endtask

  logic saw_low;

  initial begin
    repeat (3) @(posedge clk_sys);
    #1;
    check_reset_values("por");
    reset = 1'b0;
    idle(2);

    // Full sequential load covering every region boundary.
    rise();
    load_image(1'b0, 0, int'(R3));
    idle(2);
    check_status("full");
    check("full_core_reset_loading", 32'(core_reset), 32'h1);
    fall(1'b0);
    measure_release("full_release_cycles", HOLD);
    check("full_load_ok", 32'(load_ok), 32'h1);
    check("full_load_err", 32'(load_err), 32'h0);

    // Re-download from RUN followed by a short load.
    idle(3);
    check("run_core_reset", 32'(core_reset), 32'h0);
    rise();
    check("redl_core_reset", 32'(core_reset), 32'h1);
    check("redl_load_ok", 32'(load_ok), 32'h0);
    check("redl_count", 32'(byte_count), 32'h0);
    for (int i = 0; i < int'(R3) / 2; i++) begin
      if ($urandom_range(3, 0) == 0) idle(1);
      put({9'd0, 16'($urandom_range(int'(R3) - 1, 0))}, 8'($urandom));
    end
    idle(2);
    check_status("short");
    fall(1'b0);
    measure_release("short_stays_reset", HOLD + 50);
    check_status("short_end");
    check("short_load_ok", 32'(load_ok), 32'h0);

    // Full load with two out-of-range writes mixed in.
    rise();
    load_image(1'b1, 0, int'(R3) / 2);
    put(25'h1_0000, 8'($urandom));
    check("oor_err_sticky", 32'(load_err), 32'h1);
    load_image(1'b1, int'(R3) / 2, int'(R3));
    put({9'd0, R3}, 8'($urandom));
    idle(2);
    check_status("oor");
    fall(1'b0);
    measure_release("oor_stays_reset", HOLD + 50);
    check("oor_load_ok", 32'(load_ok), 32'h0);
    check("oor_load_err", 32'(load_err), 32'h1);

    // Write in the fall cycle is dropped; re-download during HOLD aborts it.
    rise();
    load_image(1'b1, 0, int'(R3));
    idle(2);
    fall(1'b1);
    saw_low = 1'b0;
    check("edge_count", 32'(byte_count), 32'(R3));
    repeat (5) begin
      if (core_reset !== 1'b1) saw_low = 1'b1;
      idle(1);
    end
    ioctl_download = 1'b1;
    repeat (3) begin
      @(posedge clk_sys); #1;
      if (core_reset !== 1'b1) saw_low = 1'b1;
    end
    exp_count = 0;
    exp_err   = 1'b0;
    check("abort_core_reset_low_seen", 32'(saw_low), 32'h0);
    check("abort_count_cleared", 32'(byte_count), 32'h0);
    put({9'd0, R1}, 8'($urandom));
    put({9'd0, R2}, 8'($urandom));
    idle(2);
    check_status("abort_load");
    fall(1'b0);
    measure_release("abort_short_stays_reset", HOLD + 50);
    check("abort_load_err", 32'(load_err), 32'h1);

    // Asynchronous reset in the middle of a load.
    rise();
    load_image(1'b0, 0, 16'h100);
    idle(1);
    #6;
    reset = 1'b1;
    #1;
    check_reset_values("async");
    check("async_sb_empty", 32'(sb_q.size()), 32'h0);
    exp_count = 0;
    exp_err   = 1'b0;
    @(posedge clk_sys); #1;
    @(posedge clk_sys); #1;
    reset = 1'b0;
    @(posedge clk_sys); #1;
    put({9'd0, 16'($urandom_range(int'(R3) - 1, 0))}, 8'($urandom));
    idle(2);
    check_status("post_reset_load");
    fall(1'b0);
    measure_release("post_reset_stays_reset", HOLD + 50);
    check("post_reset_err", 32'(load_err), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
